// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, NOP word,
// default reset PC and a word-alignment helper.
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_DRAIN,
    ST_ERR
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/pc_register.sv
// Program counter with redirect/increment select; redirect has priority and
// the loaded target is always forced to a word boundary.
module pc_register
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load_target,
  input  logic [31:0] target,
  input  logic        advance,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] pc_inc;

  // Natural 32-bit overflow gives the FFFF_FFFC -> 0000_0000 wrap.
  assign pc_inc = pc_q + 32'd4;

  always_comb begin
    pc_d = pc_q;
    if (load_target) begin
      pc_d = align_word(target);
    end else if (advance) begin
      pc_d = pc_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q <= align_word(RESET_PC);
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc       = pc_q;
  assign pc_plus4 = pc_inc;

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding-request instruction fetch unit: issues one request,
// waits for the response, holds the instruction until the decoder takes it.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  input  logic        instr_ack,
  output logic        fetch_err
);

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  fetch_state_t state_q, state_d;
  logic [7:0]   wait_cnt_q, wait_cnt_d;
  logic [31:0]  instr_q, instr_d;
  logic         err_q, err_d;
  logic         pc_load;
  logic         pc_advance;

  pc_register #(
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_target(pc_load),
    .target     (redirect_target),
    .advance    (pc_advance),
    .pc         (pc),
    .pc_plus4   (pc_plus4)
  );

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    instr_d    = instr_q;
    err_d      = err_q;
    pc_load    = 1'b0;
    pc_advance = 1'b0;

    case (state_q)
      ST_REQ: begin
        if (redirect) begin
          pc_load = 1'b1;
        end else begin
          state_d    = ST_WAIT;
          wait_cnt_d = 8'd0;
        end
      end

      // DRAIN shares WAIT's timeout; its response is simply never kept.
      ST_WAIT, ST_DRAIN: begin
        if (imem_rvalid) begin
          state_d = ST_REQ;
          if (redirect) begin
            pc_load = 1'b1;
          end else if (state_q == ST_WAIT) begin
            instr_d = imem_rdata;
            state_d = ST_HOLD;
          end
        end else if (wait_cnt_q == WAIT_LIMIT) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
          if (redirect) begin
            pc_load = 1'b1;
            state_d = ST_DRAIN;
          end
        end
      end

      ST_HOLD: begin
        if (redirect) begin
          pc_load = 1'b1;
          state_d = ST_REQ;
        end else if (instr_ack) begin
          pc_advance = 1'b1;
          state_d    = ST_REQ;
        end
      end

      ST_ERR: begin
      end

      default: begin
        state_d = ST_REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_REQ;
      wait_cnt_q <= 8'd0;
      instr_q    <= NOP_INSTR;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      instr_q    <= instr_d;
      err_q      <= err_d;
    end
  end

  // Gated by reset_n so nothing is requested or presented while in reset.
  assign imem_req    = reset_n && (state_q == ST_REQ);
  assign instr_valid = reset_n && (state_q == ST_HOLD);
  assign imem_addr   = pc;
  assign instr       = instr_q;
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// traffic, all compared against a transaction-level model of the fetch rules.
module tb_fetch_unit;

  localparam int          MW  = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_rvalid = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        instr_ack = 1'b0;
  logic        fetch_err;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .MAX_WAIT(MW)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_rvalid    (imem_rvalid),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .instr          (instr),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .instr_valid    (instr_valid),
    .instr_ack      (instr_ack),
    .fetch_err      (fetch_err)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Memory environment: one pending request, answered after a random latency.
  bit          mem_on  = 1'b1;
  bit          spur_on = 1'b0;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          pend    = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  int          due     = 0;

  // Reference model: pending fetch, outstanding request, held instruction.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  bit          m_issue, m_busy, m_discard, m_hold, m_err;
  int          m_age;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h00A0_0113;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("[TB] FAIL %s at cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc      = 32'h0;
    m_instr   = NOP;
    m_issue   = 1'b1;
    m_busy    = 1'b0;
    m_discard = 1'b0;
    m_hold    = 1'b0;
    m_err     = 1'b0;
    m_age     = 0;
  endtask

  task automatic model_step();
    logic [31:0] tgt;
    tgt = redirect_target & ~32'h3;
    if (!reset_n) begin
      model_reset();
    end else if (m_err) begin
    end else if (m_issue) begin
      if (redirect) m_pc = tgt;
      else begin
        m_issue = 1'b0; m_busy = 1'b1; m_discard = 1'b0; m_age = 0;
      end
    end else if (m_busy) begin
      if (imem_rvalid) begin
        m_busy = 1'b0;
        if (redirect) begin
          m_pc = tgt; m_issue = 1'b1;
        end else if (m_discard) m_issue = 1'b1;
        else begin
          m_instr = imem_rdata; m_hold = 1'b1;
        end
      end else if (m_age == MW) begin
        m_err = 1'b1; m_busy = 1'b0;
      end else begin
        m_age++;
        if (redirect) begin
          m_pc = tgt; m_discard = 1'b1;
        end
      end
    end else if (m_hold) begin
      if (redirect) begin
        m_pc = tgt; m_hold = 1'b0; m_issue = 1'b1;
      end else if (instr_ack) begin
        m_pc = m_pc + 32'd4; m_hold = 1'b0; m_issue = 1'b1;
      end
    end
  endtask

  task automatic applyStimulus();
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (!reset_n) begin
      pend = 1'b0;
    end else begin
      if (pend && due == cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend_addr);
        pend        = 1'b0;
      end
      if (imem_req === 1'b1 && mem_on) begin
        pend      = 1'b1;
        pend_addr = imem_addr;
        due       = cyc + int'($urandom_range(lat_max, lat_min));
      end
      if (spur_on && !imem_rvalid && !m_busy && $urandom_range(3, 0) == 0)
        imem_rvalid = 1'b1;
    end
  endtask

  task automatic checkCycle();
    checkOutput("imem_req", imem_req, m_issue && reset_n);
    if (m_issue && reset_n) checkOutput("imem_addr", imem_addr, m_pc);
    checkOutput("instr_valid", instr_valid, m_hold && reset_n);
    checkOutput("pc", pc, m_pc);
    checkOutput("pc_plus4", pc_plus4, m_pc + 32'd4);
    checkOutput("instr", instr, m_instr);
    checkOutput("fetch_err", fetch_err, m_err);
  endtask

  task automatic tick();
    #1;
    applyStimulus();
    #1;
    checkCycle();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
  endtask

  task automatic wait_issue(input string tag, input int budget);
    int n;
    n = 0;
    while (!m_issue && n < budget) begin
      tick();
      n++;
    end
    n_cmp++;
    assert (n < budget)
    else begin
      n_err++;
      $error("[TB] FAIL %s: no request within %0d cycles (observed %0d, required < %0d)", tag, budget, n, budget);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    tick();
    checkOutput("rst_req", imem_req, 1'b0);
    checkOutput("rst_valid", instr_valid, 1'b0);
    checkOutput("rst_pc", pc, 32'h0);
    checkOutput("rst_instr", instr, NOP);
    checkOutput("rst_err", fetch_err, 1'b0);

    // Two back-to-back fetches from a one-cycle memory.
    reset_n = 1'b1; instr_ack = 1'b1; #1;
    checkOutput("f0_req", imem_req, 1'b1);
    checkOutput("f0_addr", imem_addr, 32'h0);
    tick(); tick();
    checkOutput("f0_valid", instr_valid, 1'b1);
    checkOutput("f0_pc", pc, 32'h0);
    checkOutput("f0_pc4", pc_plus4, 32'h4);
    checkOutput("f0_instr", instr, 32'h0050_0093);
    tick();
    checkOutput("f1_addr", imem_addr, 32'h4);
    tick(); tick();
    checkOutput("f1_valid", instr_valid, 1'b1);
    checkOutput("f1_pc", pc, 32'h4);
    checkOutput("f1_pc4", pc_plus4, 32'h8);
    checkOutput("f1_instr", instr, 32'h00A0_0113);

    // Redirect together with ack in HOLD: target wins over pc+4.
    redirect = 1'b1; redirect_target = 32'h100;
    tick();
    redirect = 1'b0;
    checkOutput("redir_hold_addr", imem_addr, 32'h100);

    // Redirect in WAIT with a slow memory: response is drained, not kept.
    lat_min = 3; lat_max = 3;
    tick();
    redirect = 1'b1; redirect_target = 32'h203;
    tick();
    redirect = 1'b0;
    checkOutput("drain_valid", instr_valid, 1'b0);
    wait_issue("drain_bound", 10);
    checkOutput("drain_addr", imem_addr, 32'h200);
    checkOutput("drain_instr", instr, 32'h00A0_0113);
    lat_min = 1; lat_max = 1; instr_ack = 1'b0;
    tick(); tick();
    checkOutput("drain_new_valid", instr_valid, 1'b1);
    checkOutput("drain_new_instr", instr, mem_word(32'h200));

    // PC wrap at the top of the address space.
    redirect = 1'b1; redirect_target = 32'hFFFF_FFFE;
    tick();
    redirect = 1'b0;
    checkOutput("wrap_addr_hi", imem_addr, 32'hFFFF_FFFC);
    tick(); tick();
    checkOutput("wrap_pc4", pc_plus4, 32'h0);
    instr_ack = 1'b1;
    tick();
    checkOutput("wrap_addr_lo", imem_addr, 32'h0);

    // Memory never answers: timeout, then everything ignored until reset.
    mem_on = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      checkOutput("tmo_err_early", fetch_err, 1'b0);
      tick();
    end
    checkOutput("tmo_err", fetch_err, 1'b1);
    checkOutput("tmo_req", imem_req, 1'b0);
    redirect = 1'b1; redirect_target = 32'h80;
    repeat (3) tick();
    redirect = 1'b0;
    checkOutput("err_pc", pc, 32'h0);
    checkOutput("err_sticky", fetch_err, 1'b1);
    checkOutput("err_req", imem_req, 1'b0);
    checkOutput("err_valid", instr_valid, 1'b0);

    reset_n = 1'b0;
    tick();
    reset_n = 1'b1; mem_on = 1'b1; instr_ack = 1'b0;
    checkOutput("err_clr", fetch_err, 1'b0);

    // Reset while waiting on a fetch at 0x40.
    tick(); tick();
    redirect = 1'b1; redirect_target = 32'h40;
    tick();
    redirect = 1'b0; lat_min = 3; lat_max = 3;
    tick();
    checkOutput("mid_pc", pc, 32'h40);
    reset_n = 1'b0;
    tick();
    checkOutput("mid_rst_pc", pc, 32'h0);
    checkOutput("mid_rst_err", fetch_err, 1'b0);
    checkOutput("mid_rst_instr", instr, NOP);
    checkOutput("mid_rst_valid", instr_valid, 1'b0);
    checkOutput("mid_rst_req", imem_req, 1'b0);
    reset_n = 1'b1;

    // Random traffic checked cycle by cycle against the model.
    lat_min = 1; lat_max = 3; spur_on = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      redirect  = ($urandom_range(7, 0) == 0);
      redirect_target = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom;
      instr_ack = $urandom_range(1, 0) == 1;
      reset_n   = ($urandom_range(199, 0) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
